// File: rtl/kyber_feed_pkg.sv
// Shared types and constants for the kyber_pke_enc byte feeder.
package kyber_feed_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM,
    ST_FULL,
    ST_DONE
  } feed_state_t;

  localparam int DEF_LEN    = 32;
  localparam int DEF_AW     = 8;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 9;

endpackage

// File: rtl/kyber_pke_feeder_if.sv
// Memory read port plus the readin/readin_ok byte handshake toward kyber_pke_enc.
interface kyber_pke_feeder_if #(parameter int AW = 8);

  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          readin;
  logic          readin_ok;
  logic [7:0]    kyber_din;
  logic [7:0]    kyber_in_index;
  logic          full_in;

  modport master (
    output mem_en, mem_addr, readin, kyber_din, kyber_in_index, full_in,
    input  mem_rdata, readin_ok
  );

  modport slave (
    input  mem_en, mem_addr, readin, kyber_din, kyber_in_index, full_in,
    output mem_rdata, readin_ok
  );

endinterface

// File: rtl/kyber_feed_fifo2.sv
// Two-entry byte FIFO; push and pop may coincide, including when full.
module kyber_feed_fifo2
  import kyber_feed_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic [1:0] count
);

  logic [7:0] store [FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       pop_ok;
  logic       push_ok;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'(FIFO_DEPTH));
  assign head    = store[rd_ptr];
  assign pop_ok  = pop & ~empty;
  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) store[i] <= 8'h00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kyber_pke_feeder.sv
// Streams LEN bytes from a sync-read RAM into kyber_pke_enc with element indices.
// Optional KYBER_FEED_CHKSUM_EN adds a 16-bit running byte sum output feed_sum.
module kyber_pke_feeder
  import kyber_feed_pkg::*;
#(
  parameter int LEN = DEF_LEN,
  parameter int AW  = DEF_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          set,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  output logic          busy,
  output logic          done,
`ifdef KYBER_FEED_CHKSUM_EN
  output logic [15:0]   feed_sum,
`endif
  kyber_pke_feeder_if.master bus
);

  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

  feed_state_t      state;
  logic [AW-1:0]    base_q;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] tx_cnt;
  logic             rd_inflight;

  logic       fifo_empty;
  logic       fifo_full;
  logic [1:0] fifo_count;
  logic [7:0] fifo_head;
  logic       fifo_pop;
  logic       readin;
  logic       issue_rd;
  logic [2:0] occ_after;
  logic       accept;

  kyber_feed_fifo2 u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rd_inflight),
    .push_data (bus.mem_rdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Occupancy counts the pop of this cycle so a read can be issued every cycle
  // while the core keeps readin_ok high.
  always_comb begin
    readin    = set & (state == ST_STREAM) & ~fifo_empty;
    fifo_pop  = readin & bus.readin_ok;
    accept    = set & start & (state == ST_IDLE);
    occ_after = {1'b0, fifo_count} + {2'b00, rd_inflight} - {2'b00, fifo_pop};
    issue_rd  = 1'b0;
    if (set) begin
      if (state == ST_FETCH) begin
        issue_rd = 1'b1;
      end else if (state == ST_STREAM && rd_cnt < LEN_C) begin
        issue_rd = fifo_full ? fifo_pop : (occ_after < 3'd2);
      end
    end
  end

  assign bus.mem_en         = issue_rd;
  assign bus.mem_addr       = base_q + AW'(rd_cnt);
  assign bus.readin         = readin;
  assign bus.kyber_din      = fifo_head;
  assign bus.kyber_in_index = tx_cnt[7:0];
  assign bus.full_in        = set & (state == ST_FULL);
  assign done               = set & (state == ST_DONE);
  assign busy               = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      base_q      <= '0;
      rd_cnt      <= '0;
      tx_cnt      <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= issue_rd;
      if (issue_rd) rd_cnt <= rd_cnt + 1'b1;
      if (fifo_pop) tx_cnt <= tx_cnt + 1'b1;
      if (set) begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              base_q <= base_addr;
              rd_cnt <= '0;
              tx_cnt <= '0;
              state  <= ST_FETCH;
            end
          end
          ST_FETCH:  state <= ST_STREAM;
          ST_STREAM: if (fifo_pop && tx_cnt == LAST_C) state <= ST_FULL;
          ST_FULL:   state <= ST_DONE;
          ST_DONE:   state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef KYBER_FEED_CHKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= 16'h0000;
    end else if (accept) begin
      sum_q <= 16'h0000;
    end else if (fifo_pop) begin
      sum_q <= sum_q + 16'(fifo_head);
    end
  end

  assign feed_sum = sum_q;
`endif

endmodule

// File: tb/tb_kyber_pke_feeder.sv
// Self-checking bench for kyber_pke_feeder; scoreboard queues filled at start, drained per transfer.
module tb_kyber_pke_feeder;

  localparam int LEN  = 32;
  localparam int LEN2 = 256;
  localparam int AW   = 8;

  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] din;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          set;
  logic          start;
  logic          start2;
  logic [AW-1:0] base_addr;
  logic          busy, done, busy2, done2;
`ifdef KYBER_FEED_CHKSUM_EN
  logic [15:0]   feed_sum, feed_sum2;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] mem [256];
  exp_t       exp_q[$];
  logic [7:0] addr_q[$];
  logic [7:0] exp2_q[$];
  logic [3:0] ok_pat = 4'b1001;

  kyber_pke_feeder_if #(.AW(AW)) bus();
  kyber_pke_feeder_if #(.AW(AW)) bus2();

  always #5 clk = ~clk;

  // Synchronous-read byte RAM shared by both feeders.
  always @(posedge clk) begin
    if (bus.mem_en)  bus.mem_rdata  <= mem[bus.mem_addr];
    if (bus2.mem_en) bus2.mem_rdata <= mem[bus2.mem_addr];
  end

  kyber_pke_feeder #(.LEN(LEN), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .set       (set),
    .start     (start),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
`ifdef KYBER_FEED_CHKSUM_EN
    .feed_sum  (feed_sum),
`endif
    .bus       (bus)
  );

  kyber_pke_feeder #(.LEN(LEN2), .AW(AW)) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .set       (set),
    .start     (start2),
    .base_addr (base_addr),
    .busy      (busy2),
    .done      (done2),
`ifdef KYBER_FEED_CHKSUM_EN
    .feed_sum  (feed_sum2),
`endif
    .bus       (bus2)
  );

  // Runs one LEN-byte block on dut starting at the current negedge.
  // mode 0: readin_ok always 1; mode 1: readin_ok follows 1,0,0,1.
  task automatic run_block(input logic [7:0] b, input int mode, input int abort_at, input int hold_at);
    exp_t       e;
    logic [7:0] ea;
    logic [15:0] prev_out;
    int cyc, ntx, first_cyc, last_tx;
    bit finished, held, prev_stall;
    ntx = 0; first_cyc = -1; last_tx = -1; finished = 0; held = 0; prev_stall = 0; prev_out = '0;
    for (int i = 0; i < LEN; i++) begin
      e.idx = 8'(i);
      e.din = mem[8'(int'(b) + i)];
      exp_q.push_back(e);
      addr_q.push_back(8'(int'(b) + i));
    end
    base_addr = b;
    set = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL start_accept: busy=%b, expected 1", busy);
    end
    while (!finished && cyc < 400) begin
      start = 1'b0;
      if (abort_at >= 0 && ntx == abort_at) return;
      if (hold_at >= 0 && !held && ntx == hold_at) begin
        held = 1;
        set = 1'b0;
        #1;
        for (int h = 0; h < 5; h++) begin
          tests_run++;
          if ({bus.readin, bus.mem_en, bus.full_in, done} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL hold_quiet: readin/mem_en/full_in/done=%b, expected 0000",
                     {bus.readin, bus.mem_en, bus.full_in, done});
          end
          @(negedge clk);
        end
        set = 1'b1;
        start = 1'b1;
        base_addr = 8'h55;
      end
      bus.readin_ok = (mode == 1) ? ok_pat[cyc % 4] : 1'b1;
      #1;
      if (bus.mem_en) begin
        tests_run++;
        if (addr_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL extra_read: mem_addr=%h, expected no read", bus.mem_addr);
        end else begin
          ea = addr_q.pop_front();
          if (bus.mem_addr !== ea) begin
            tests_failed++;
            $display("[TB] FAIL mem_addr: got %h, expected %h", bus.mem_addr, ea);
          end
        end
      end
      if (first_cyc < 0 && bus.readin === 1'b1) begin
        first_cyc = cyc;
        tests_run++;
        if (cyc != 3) begin
          tests_failed++;
          $display("[TB] FAIL first_readin: cycle %0d, expected 3", cyc);
        end
      end else if (first_cyc >= 0) begin
        tests_run++;
        if (bus.readin !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL readin_gap: readin=%b at cycle %0d, expected 1", bus.readin, cyc);
        end
      end
      if (prev_stall) begin
        tests_run++;
        if ({bus.kyber_in_index, bus.kyber_din} !== prev_out) begin
          tests_failed++;
          $display("[TB] FAIL stall_stable: got %h, expected %h", {bus.kyber_in_index, bus.kyber_din}, prev_out);
        end
      end
      prev_stall = bus.readin & ~bus.readin_ok;
      prev_out   = {bus.kyber_in_index, bus.kyber_din};
      if (bus.readin && bus.readin_ok) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL extra_transfer: idx/din=%h, expected none", {bus.kyber_in_index, bus.kyber_din});
        end else begin
          e = exp_q.pop_front();
          if ({bus.kyber_in_index, bus.kyber_din} !== e) begin
            tests_failed++;
            $display("[TB] FAIL transfer: idx/din got %h, expected %h", {bus.kyber_in_index, bus.kyber_din}, e);
          end
        end
        if (mode == 0 && ntx > 0) begin
          tests_run++;
          if (cyc != last_tx + 1) begin
            tests_failed++;
            $display("[TB] FAIL throughput: transfer at cycle %0d, expected %0d", cyc, last_tx + 1);
          end
        end
        last_tx = cyc;
        ntx++;
        if (ntx == LEN) finished = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tests_run++;
    if (!finished) begin
      tests_failed++;
      $display("[TB] FAIL block_timeout: %0d transfers, expected %0d", ntx, LEN);
      exp_q.delete();
      addr_q.delete();
      return;
    end
    tests_run++;
    if (addr_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL read_count: %0d reads missing, expected 0", addr_q.size());
      addr_q.delete();
    end
    tests_run++;
    if ({bus.full_in, bus.readin, done, busy} !== 4'b1001) begin
      tests_failed++;
      $display("[TB] FAIL full_cycle: full_in/readin/done/busy=%b, expected 1001", {bus.full_in, bus.readin, done, busy});
    end
    @(negedge clk);
    tests_run++;
    if ({bus.full_in, bus.readin, done, busy} !== 4'b0011) begin
      tests_failed++;
      $display("[TB] FAIL done_cycle: full_in/readin/done/busy=%b, expected 0011", {bus.full_in, bus.readin, done, busy});
    end
    @(negedge clk);
    tests_run++;
    if ({bus.full_in, bus.readin, done, busy} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL idle_after: full_in/readin/done/busy=%b, expected 0000", {bus.full_in, bus.readin, done, busy});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    base_addr = '0;
    bus.readin_ok = 1'b0;
    bus2.readin_ok = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.readin, bus.full_in, done, busy, bus.mem_en, bus.kyber_din, bus.kyber_in_index, bus.mem_addr} !== 29'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %h, expected 0",
               {bus.readin, bus.full_in, done, busy, bus.mem_en, bus.kyber_din, bus.kyber_in_index, bus.mem_addr});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 2);
    run_block(8'h00, 0, -1, -1);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 2);
    run_block(8'h00, 1, -1, -1);
  endtask

  task automatic test_addr_wrap();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    run_block(8'hF0, 0, -1, -1);
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 2);
    run_block(8'h00, 0, 10, -1);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.readin, bus.full_in, done, busy, bus.mem_en, bus.kyber_din, bus.kyber_in_index} !== 21'h0) begin
      tests_failed++;
      $display("[TB] FAIL abort_outputs: got %h, expected 0",
               {bus.readin, bus.full_in, done, busy, bus.mem_en, bus.kyber_din, bus.kyber_in_index});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    addr_q.delete();
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if ({bus.full_in, done, busy} !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL abort_no_done: full_in/done/busy=%b, expected 000", {bus.full_in, done, busy});
      end
    end
    run_block(8'h00, 0, -1, -1);
  endtask

  task automatic test_hold();
    for (int i = 0; i < 256; i++) mem[i] = 8'(8'h80 ^ i);
    run_block(8'h10, 0, -1, 12);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) mem[i] = 8'(3 * i + 7);
    run_block(8'h20, 0, -1, -1);
    run_block(8'h40, 1, -1, -1);
  endtask

  task automatic test_len256();
    int cyc, ntx;
    logic [7:0] ei;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    for (int i = 0; i < LEN2; i++) exp2_q.push_back(8'(i));
    base_addr = 8'h00;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    bus2.readin_ok = 1'b1;
    cyc = 0;
    ntx = 0;
    while (ntx < LEN2 && cyc < 700) begin
      if (bus2.readin && bus2.readin_ok) begin
        tests_run++;
        ei = exp2_q.pop_front();
        if (bus2.kyber_in_index !== ei || bus2.kyber_din !== 8'hFF) begin
          tests_failed++;
          $display("[TB] FAIL len256_transfer: idx/din %h/%h, expected %h/ff", bus2.kyber_in_index, bus2.kyber_din, ei);
        end
        ntx++;
      end
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (ntx != LEN2 || bus2.full_in !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL len256_full: %0d transfers full_in=%b, expected 256 and 1", ntx, bus2.full_in);
    end
`ifdef KYBER_FEED_CHKSUM_EN
    tests_run++;
    if (feed_sum2 !== 16'hFF00) begin
      tests_failed++;
      $display("[TB] FAIL feed_sum: got %h, expected ff00", feed_sum2);
    end
`endif
    @(negedge clk);
    tests_run++;
    if (done2 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL len256_done: done=%b, expected 1", done2);
    end
`ifdef KYBER_FEED_CHKSUM_EN
    tests_run++;
    if (feed_sum2 !== 16'hFF00) begin
      tests_failed++;
      $display("[TB] FAIL feed_sum_hold: got %h, expected ff00", feed_sum2);
    end
`endif
    @(negedge clk);
    exp2_q.delete();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_addr_wrap();
    test_reset_abort();
    test_hold();
    test_back_to_back();
    test_len256();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
